axa_fetch_queue: RTL and testbench
==================================

// Module: axa_fetch_queue
// PURPOSE
//  Instruction fetch unit feeding the AXA decode stage (stage 1). Owns the PC, issues
//  reads to instruction memory forward (pc+1) or reverse (pc-1), and buffers returned
//  words in a small FIFO. Flushes on branch/jerr redirect; holds on pipeline stall.
// PARAMETERS
//  DEPTH  4   queue entries; power of 2, >=2
//  AW     16  instruction address width
//  IW     16  instruction word width
// PORTS
//  clk          in   1   clock, all state on posedge
//  reset        in   1   asynchronous, active-low reset
//  im_req       out  1   read strobe to instruction memory
//  im_addr      out  AW  read address; data returns exactly 1 cycle later
//  im_data      in   IW  instruction word for the request of the previous cycle
//  dir          in   1   1=forward (errors==0), 0=reverse execution
//  blocked      in   1   1=issue no new fetches (sys/fail/branch pending downstream)
//  redirect     in   1   taken branch / reverse jerr: flush and restart
//  redirect_pc  in   AW  restart address
//  out_valid    out  1   queue head valid
//  out_ready    in   1   decode accepts head
//  out_ir       out  IW  head instruction; NOP 16'hE800 ({6'b111010,10'b0}) when !out_valid
//  out_pc       out  AW  address of head instruction
//  out_fwd      out  1   dir value at issue of head instruction
//  out_lastpc   out  AW  (AXA_FETCH_LASTPC_EN only) see CONFIGURATION
// BEHAVIOUR
//  - Reset (reset==0): pc=0, queue empty, in-flight cleared, im_req=0, im_addr=0,
//    out_valid=0, out_ir=16'hE800, out_pc=0, out_fwd=1, out_lastpc=0; effect immediate.
//  - Issue: im_req=1, im_addr=pc when !redirect && !blocked && (count+inflight)<DEPTH.
//    On issue pc <= dir ? pc+1 : pc-1, modulo 2^AW (0-1 -> FFFF, FFFF+1 -> 0).
//  - Return: in-flight flag set on issue; next edge im_data pushed with {pc,fwd} tag.
//    Issue-to-out_valid latency 2 edges when queue empty; no bypass.
//  - Pop: head removed on edge where out_valid && out_ready. Push and pop in same cycle
//    allowed at full (count unchanged). Never push when full (issue rule guarantees).
//  - Redirect (priority over all): queue flushed, in-flight return discarded (epoch
//    bit toggled, stale data dropped), pc <= redirect_pc, no issue that cycle; simultaneous
//    pop is ignored. out_valid low for 2 edges after redirect edge, then redirect_pc word.
//  - blocked: in-flight return still enqueued; queued entries still drain.
//  - dir change takes effect on next issue only; queued entries keep their out_fwd tag.
//  - Pointers wrap modulo DEPTH; count range 0..DEPTH.
// CONFIGURATION
//  AXA_FETCH_LASTPC_EN defined: each entry carries lastpc = address issued before it;
//   first entry after a redirect carries out_pc of the last popped instruction (land
//   source). Register resets to 0.
//  Not defined: out_lastpc port absent, no lastpc storage; land pc supplied elsewhere.
// STRUCTURE
//  - Shared header axa_defs.vh: `WORD, `INST, `OP, `OPnop, `NOP, field macros reused by decode.
//  - Sub-module axa_fifo (DEPTH x width, push/pop/flush, count, async active-low reset)
//    holds {ir,pc,fwd[,lastpc]}; top level holds pc, in-flight/epoch, issue logic.
// TESTING
//  1 Release reset, dir=1, out_ready=1, im model returns 16'h0100+addr -> out_ir 0100,0101,
//    0102.. with out_pc 0,1,2; first out_valid 2 edges after first posedge out of reset.
//  2 out_ready=0 for 10 cycles, DEPTH=4 -> exactly 4 issues, im_req then 0; on release
//    out_pc 0..3 in order, fetching resumes at 4, no loss/duplication.
//  3 Queue holding 3 entries + in-flight, redirect=1 redirect_pc=0x0040 with out_ready=1
//    -> out_valid 0 for 2 edges, next out_pc 0x0040; no stale word appears.
//  4 dir=0 from pc=1 -> out_pc 1,0,FFFF,FFFE with out_fwd=0.
//  5 Drop reset mid-stream (between edges) -> out_valid=0, out_ir=E800 immediately; after
//    release fetch restarts at pc 0.
//  6 LASTPC_EN: pop pc 5, then redirect to 0x0014 -> entry out_pc 0x0014, out_lastpc 5;
//    following entry out_lastpc 0x0014.

Source files
------------

// File: rtl/axa_fetch_queue_pkg.sv
// Shared AXA fetch definitions: word width and the NOP encoding decode also relies on.
package axa_fetch_queue_pkg;
  localparam int              AXA_WORD_W = 16;
  localparam logic [5:0]      AXA_OP_NOP = 6'b111010;
  localparam logic [AXA_WORD_W-1:0] AXA_NOP = {AXA_OP_NOP, 10'b0};
endpackage

// File: rtl/axa_fetch_queue_fifo.sv
// DEPTH-entry FIFO with flush; data visible on dout the edge after push, zero-latency pop.
// Flush wins over push/pop; push at full is accepted only together with a pop.
module axa_fetch_queue_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] count
);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic          do_push, do_pop;

  assign do_pop  = pop && !flush && (count != '0);
  assign do_push = push && !flush && ((count != CW'(DEPTH)) || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (do_pop && !do_push) count <= count - CW'(1);
    end
  end
endmodule

// File: rtl/axa_fetch_queue.sv
// AXA fetch: owns PC, issues fwd/rev reads, queues returns; issue-to-valid 2 edges, no bypass.
// Issue stops when queue+in-flight reaches DEPTH or blocked; AXA_FETCH_LASTPC_EN adds out_lastpc.
module axa_fetch_queue
  import axa_fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 16,
  parameter int IW    = 16
) (
  input  logic          clk,
  input  logic          reset,
  output logic          im_req,
  output logic [AW-1:0] im_addr,
  input  logic [IW-1:0] im_data,
  input  logic          dir,
  input  logic          blocked,
  input  logic          redirect,
  input  logic [AW-1:0] redirect_pc,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [IW-1:0] out_ir,
  output logic [AW-1:0] out_pc,
  output logic          out_fwd
`ifdef AXA_FETCH_LASTPC_EN
  ,
  output logic [AW-1:0] out_lastpc
`endif
);
  localparam int CW = $clog2(DEPTH + 1);
`ifdef AXA_FETCH_LASTPC_EN
  localparam int EW = IW + 2 * AW + 1;
`else
  localparam int EW = IW + AW + 1;
`endif

  logic [AW-1:0] pc, infl_pc, head_pc;
  logic          inflight, infl_fwd, head_fwd;
  logic          issue, pop;
  logic [CW-1:0] count;
  logic [CW:0]   occ;
  logic [EW-1:0] din, dout;
  logic [IW-1:0] head_ir;

  // Occupancy counts the in-flight read so a returning word always has a slot.
  assign occ       = {1'b0, count} + {{CW{1'b0}}, inflight};
  assign issue     = !redirect && !blocked && (occ < (CW + 1)'(DEPTH));
  assign im_req    = issue && reset;
  assign im_addr   = pc;
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;

  // Clearing inflight on redirect drops the stale return that lands next edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc       <= '0;
      inflight <= 1'b0;
      infl_pc  <= '0;
      infl_fwd <= 1'b1;
    end else begin
      inflight <= issue;
      if (issue) begin
        infl_pc  <= pc;
        infl_fwd <= dir;
      end
      if (redirect)   pc <= redirect_pc;
      else if (issue) pc <= dir ? pc + AW'(1) : pc - AW'(1);
    end
  end

`ifdef AXA_FETCH_LASTPC_EN
  logic [AW-1:0] last_issued, last_popped, infl_lastpc, head_lastpc;

  // After a redirect the landing entry points back at the last instruction decode consumed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_issued <= '0;
      last_popped <= '0;
      infl_lastpc <= '0;
    end else begin
      if (redirect)   last_issued <= last_popped;
      else if (issue) last_issued <= pc;
      if (issue) infl_lastpc <= last_issued;
      if (pop && !redirect) last_popped <= head_pc;
    end
  end

  assign din = {im_data, infl_pc, infl_fwd, infl_lastpc};
  assign {head_ir, head_pc, head_fwd, head_lastpc} = dout;
  assign out_lastpc = out_valid ? head_lastpc : '0;
`else
  assign din = {im_data, infl_pc, infl_fwd};
  assign {head_ir, head_pc, head_fwd} = dout;
`endif

  axa_fetch_queue_fifo #(
    .DEPTH (DEPTH),
    .W     (EW),
    .CW    (CW)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (redirect),
    .push  (inflight),
    .pop   (pop),
    .din   (din),
    .dout  (dout),
    .count (count)
  );

  assign out_ir  = out_valid ? head_ir : IW'(AXA_NOP);
  assign out_pc  = out_valid ? head_pc : '0;
  assign out_fwd = out_valid ? head_fwd : 1'b1;
endmodule

// File: tb/tb_axa_fetch_queue.sv
// Bench for axa_fetch_queue: directed scenarios plus randomized traffic against an issue/pop log model.
module tb_axa_fetch_queue;
  localparam int DEPTH = 4;

  logic        clk = 1'b0, reset = 1'b0;
  logic        im_req, out_valid, out_fwd;
  logic [15:0] im_addr, out_ir, out_pc;
  logic [15:0] im_data = 16'h0;
  logic [15:0] redirect_pc = 16'h0;
  logic        dir = 1'b1, blocked = 1'b0, redirect = 1'b0, out_ready = 1'b0;
`ifdef AXA_FETCH_LASTPC_EN
  logic [15:0] out_lastpc;
`endif
  int checks = 0, failures = 0;

  axa_fetch_queue #(.DEPTH(DEPTH), .AW(16), .IW(16)) dut (
    .clk(clk), .reset(reset), .im_req(im_req), .im_addr(im_addr), .im_data(im_data),
    .dir(dir), .blocked(blocked), .redirect(redirect), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_ir(out_ir), .out_pc(out_pc),
    .out_fwd(out_fwd)
`ifdef AXA_FETCH_LASTPC_EN
    , .out_lastpc(out_lastpc)
`endif
  );

  always #5 clk = ~clk;

  // Instruction memory: word = 0x0100 + address, returned one cycle after the request.
  always @(posedge clk) im_data <= im_req ? 16'h0100 + im_addr : 16'hDEAD;

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; redirect = 1'b0; blocked = 1'b0; out_ready = 1'b0; dir = 1'b1;
    step(); step();
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    step(); step();
    checks++; if (im_req !== 1'b0) begin failures++; $display("FAIL reset_im_req got=%b exp=0", im_req); end
    checks++; if (im_addr !== 16'h0) begin failures++; $display("FAIL reset_im_addr got=%h exp=0000", im_addr); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    checks++; if (out_ir !== 16'hE800) begin failures++; $display("FAIL reset_ir got=%h exp=e800", out_ir); end
    checks++; if (out_pc !== 16'h0) begin failures++; $display("FAIL reset_pc got=%h exp=0000", out_pc); end
    checks++; if (out_fwd !== 1'b1) begin failures++; $display("FAIL reset_fwd got=%b exp=1", out_fwd); end
`ifdef AXA_FETCH_LASTPC_EN
    checks++; if (out_lastpc !== 16'h0) begin failures++; $display("FAIL reset_lastpc got=%h exp=0000", out_lastpc); end
`endif
  endtask

  task automatic test_forward();
    do_reset();
    out_ready = 1'b1;
    step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL fwd_valid_e1 got=%b exp=0", out_valid); end
    step();
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL fwd_valid_e2 got=%b exp=1", out_valid); end
    for (int k = 0; k < 6; k++) begin
      if (k > 0) step();
      checks++;
      if (out_pc !== 16'(k) || out_ir !== 16'h0100 + 16'(k) || out_fwd !== 1'b1) begin
        failures++; $display("FAIL fwd_stream got pc=%h ir=%h fwd=%b exp pc=%h ir=%h fwd=1",
                             out_pc, out_ir, out_fwd, 16'(k), 16'h0100 + 16'(k));
      end
    end
  endtask

  task automatic test_stall();
    int n = 0, exp = 0;
    do_reset();
    out_ready = 1'b0;
    repeat (10) begin
      #1; if (im_req) n++;
      @(negedge clk);
    end
    #1;
    checks++; if (n !== 4) begin failures++; $display("FAIL stall_issues got=%0d exp=4", n); end
    checks++; if (im_req !== 1'b0) begin failures++; $display("FAIL stall_req_hold got=%b exp=0", im_req); end
    out_ready = 1'b1;
    for (int c = 0; c < 40 && exp < 8; c++) begin
      if (out_valid && out_ready) begin
        checks++;
        if (out_pc !== 16'(exp) || out_ir !== 16'h0100 + 16'(exp)) begin
          failures++; $display("FAIL stall_drain got pc=%h ir=%h exp pc=%h", out_pc, out_ir, 16'(exp));
        end
        exp++;
      end
      @(negedge clk); #1;
    end
    checks++; if (exp !== 8) begin failures++; $display("FAIL stall_timeout got=%0d pops exp=8", exp); end
  endtask

  task automatic test_redirect();
    do_reset();
    out_ready = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL redir_pre_valid got=%b exp=1", out_valid); end
    redirect = 1'b1; redirect_pc = 16'h0040; out_ready = 1'b1;
    step();
    redirect = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL redir_valid_r0 got=%b exp=0", out_valid); end
    step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL redir_valid_r1 got=%b exp=0", out_valid); end
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 16'h0040 + 16'(k) || out_ir !== 16'h0140 + 16'(k)) begin
        failures++; $display("FAIL redir_stream got v=%b pc=%h ir=%h exp v=1 pc=%h", out_valid, out_pc,
                             out_ir, 16'h0040 + 16'(k));
      end
    end
  endtask

  task automatic test_reverse();
    logic [15:0] pcs [4];
    int i = 0;
    pcs[0] = 16'h0001; pcs[1] = 16'h0000; pcs[2] = 16'hFFFF; pcs[3] = 16'hFFFE;
    do_reset();
    redirect = 1'b1; redirect_pc = 16'h0001; dir = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    redirect = 1'b0;
    for (int c = 0; c < 30 && i < 4; c++) begin
      @(negedge clk); #1;
      if (out_valid && out_ready) begin
        checks++;
        if (out_pc !== pcs[i] || out_fwd !== 1'b0 || out_ir !== 16'h0100 + pcs[i]) begin
          failures++; $display("FAIL rev_stream got pc=%h fwd=%b ir=%h exp pc=%h fwd=0 ir=%h",
                               out_pc, out_fwd, out_ir, pcs[i], 16'h0100 + pcs[i]);
        end
        i++;
      end
    end
    checks++; if (i !== 4) begin failures++; $display("FAIL rev_timeout got=%0d pops exp=4", i); end
    dir = 1'b1;
  endtask

  task automatic test_async_reset();
    int exp = 0;
    dir = 1'b1; out_ready = 1'b1; redirect = 1'b0; blocked = 1'b0;
    repeat (5) step();
    #3; reset = 1'b0; #1;
    checks++; if (out_valid !== 1'b0 || out_ir !== 16'hE800 || im_req !== 1'b0) begin
      failures++; $display("FAIL arst_immediate got v=%b ir=%h req=%b exp v=0 ir=e800 req=0", out_valid, out_ir, im_req);
    end
    @(negedge clk); reset = 1'b1;
    for (int c = 0; c < 20 && exp < 2; c++) begin
      #1;
      if (out_valid && out_ready) begin
        checks++;
        if (out_pc !== 16'(exp)) begin failures++; $display("FAIL arst_restart got pc=%h exp=%h", out_pc, 16'(exp)); end
        exp++;
      end
      @(negedge clk);
    end
    checks++; if (exp !== 2) begin failures++; $display("FAIL arst_timeout got=%0d pops exp=2", exp); end
  endtask

`ifdef AXA_FETCH_LASTPC_EN
  task automatic test_lastpc();
    bit hit = 0;
    do_reset();
    out_ready = 1'b1;
    for (int c = 0; c < 30 && !hit; c++) begin
      #1;
      if (out_valid && out_pc == 16'h0003) begin
        checks++; if (out_lastpc !== 16'h0002) begin failures++; $display("FAIL lastpc_stream got=%h exp=0002", out_lastpc); end
      end
      if (out_valid && out_pc == 16'h0005) hit = 1;
      else @(negedge clk);
    end
    checks++; if (!hit) begin failures++; $display("FAIL lastpc_timeout got no pc 5 exp pc 5"); end
    @(posedge clk); #1;
    redirect = 1'b1; redirect_pc = 16'h0014;
    @(posedge clk); #1;
    redirect = 1'b0;
    hit = 0;
    for (int c = 0; c < 10 && !hit; c++) begin
      if (out_valid) hit = 1; else step();
    end
    checks++; if (out_pc !== 16'h0014 || out_lastpc !== 16'h0005) begin
      failures++; $display("FAIL lastpc_land got pc=%h last=%h exp pc=0014 last=0005", out_pc, out_lastpc);
    end
    step();
    checks++; if (out_pc !== 16'h0015 || out_lastpc !== 16'h0014) begin
      failures++; $display("FAIL lastpc_next got pc=%h last=%h exp pc=0015 last=0014", out_pc, out_lastpc);
    end
  endtask
`endif

  // Model: log of issued-but-not-consumed {pc,dir}; issue allowed while the log is below DEPTH.
  task automatic test_random();
    logic [16:0] log_q [$];
    logic [16:0] e;
    logic [15:0] ipc = 16'h0;
    bit          exp_iss;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      dir         = ($urandom_range(0, 3) != 0);
      blocked     = ($urandom_range(0, 3) == 0);
      out_ready   = ($urandom_range(0, 2) != 0);
      redirect    = ($urandom_range(0, 24) == 0);
      redirect_pc = 16'($urandom);
      #1;
      if (redirect) begin
        checks++; if (im_req !== 1'b0) begin failures++; $display("FAIL rnd_redir_req got=%b exp=0", im_req); end
        log_q.delete();
        ipc = redirect_pc;
      end else begin
        exp_iss = !blocked && (log_q.size() < DEPTH);
        checks++; if (im_req !== exp_iss) begin failures++; $display("FAIL rnd_issue got=%b exp=%b", im_req, exp_iss); end
        if (!out_valid) begin
          checks++; if (out_ir !== 16'hE800) begin failures++; $display("FAIL rnd_nop got=%h exp=e800", out_ir); end
        end else if (out_ready) begin
          checks++;
          if (log_q.size() == 0) begin
            failures++; $display("FAIL rnd_pop_empty got pc=%h exp no valid entry", out_pc);
          end else begin
            e = log_q.pop_front();
            if (out_pc !== e[16:1] || out_fwd !== e[0] || out_ir !== 16'h0100 + e[16:1]) begin
              failures++; $display("FAIL rnd_pop got pc=%h fwd=%b ir=%h exp pc=%h fwd=%b ir=%h",
                                   out_pc, out_fwd, out_ir, e[16:1], e[0], 16'h0100 + e[16:1]);
            end
          end
        end
        if (exp_iss) begin
          checks++; if (im_addr !== ipc) begin failures++; $display("FAIL rnd_addr got=%h exp=%h", im_addr, ipc); end
          log_q.push_back({ipc, dir});
          ipc = dir ? ipc + 16'd1 : ipc - 16'd1;
        end
      end
      @(negedge clk);
    end
    redirect = 1'b0; blocked = 1'b0; dir = 1'b1;
  endtask

  initial begin
    test_reset();
    test_forward();
    test_stall();
    test_redirect();
    test_reverse();
    test_async_reset();
`ifdef AXA_FETCH_LASTPC_EN
    test_lastpc();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
